// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the display scan driver
// Segment patterns are {dp,g,f,e,d,c,b,a}, active-high.
package display_pkg;

  typedef enum logic [2:0] {IDLE, CONV_S, CONV_M, CONV_H, COMMIT} conv_state_t;

  localparam int SEC  = 0;
  localparam int MIN  = 1;
  localparam int HOUR = 2;

  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [4:0] MAX_HOUR = 5'd23;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [9:0][7:0] SEG_DIGIT = {8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
                                           8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};

  function automatic logic [5:0] sat6(input logic [5:0] v, input logic [5:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD digit to 7-segment pattern, codes above 9 blank
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/time_bin2bcd_seq.sv
// rtl/time_bin2bcd_seq.sv - saturating capture and sequential binary-to-BCD of HH:MM:SS
// digits[] order: sec ones, sec tens, min ones, min tens, hour ones, hour tens.
module time_bin2bcd_seq
  import display_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            upd,
  input  logic [4:0]      hour,
  input  logic [5:0]      minute,
  input  logic [5:0]      second,
  output logic            busy,
  output logic            done,
  output logic [5:0][3:0] digits
);

  conv_state_t state, state_nxt;
  logic [5:0] rem;
  logic [3:0] tens;
  logic [5:0] cap_m;
  logic [4:0] cap_h;
  logic [5:0][3:0] shadow;
  logic rem_ge10;

  assign rem_ge10 = (rem >= 6'd10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == COMMIT);
    case (state)
      IDLE:    if (upd) state_nxt = CONV_S;
      CONV_S:  if (!rem_ge10) state_nxt = CONV_M;
      CONV_M:  if (!rem_ge10) state_nxt = CONV_H;
      CONV_H:  if (!rem_ge10) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One shared remainder/tens pair walks through the fields; shadow holds results until COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    <= '0;
      tens   <= '0;
      cap_m  <= '0;
      cap_h  <= '0;
      shadow <= '0;
      digits <= '0;
    end else begin
      case (state)
        IDLE: if (upd) begin
          rem   <= sat6(second, MAX_SEC);
          cap_m <= sat6(minute, MAX_MIN);
          cap_h <= (hour > MAX_HOUR) ? MAX_HOUR : hour;
          tens  <= '0;
        end
        CONV_S, CONV_M, CONV_H: begin
          if (rem_ge10) begin
            rem  <= rem - 6'd10;
            tens <= tens + 4'd1;
          end else begin
            tens <= '0;
            if (state == CONV_S) begin
              shadow[2*SEC]   <= rem[3:0];
              shadow[2*SEC+1] <= tens;
              rem             <= cap_m;
            end else if (state == CONV_M) begin
              shadow[2*MIN]   <= rem[3:0];
              shadow[2*MIN+1] <= tens;
              rem             <= {1'b0, cap_h};
            end else begin
              shadow[2*HOUR]   <= rem[3:0];
              shadow[2*HOUR+1] <= tens;
            end
          end
        end
        COMMIT:  digits <= shadow;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - multiplexed 7-segment HHMMSS/HHMM scan driver with field blink
// Optional DISPLAY_COLON_BLINK_EN: dp of hour-ones (and minute-ones at 6 digits) blinks as a colon.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 1000,
  parameter int BLINK_DIV      = 250,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd,
  input  logic [4:0]            hour,
  input  logic [5:0]            minute,
  input  logic [5:0]            second,
  input  logic [2:0]            blink_mask,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [7:0]            seg_out
);

  if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_digits
    $error("NUM_DIGITS must be 4 or 6");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan
    $error("SCAN_DIV must be at least 2");
  end

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
  localparam logic [2:0] DIG_OFF  = (NUM_DIGITS == 4) ? 3'd2 : 3'd0;
  localparam logic [NUM_DIGITS-1:0] SEL_POL = {NUM_DIGITS{SEG_ACTIVE_LOW}};
  localparam logic [7:0] SEG_POL = {8{SEG_ACTIVE_LOW}};

  logic [5:0][3:0] digits;
  logic [PW-1:0] presc;
  logic [BW-1:0] bcnt;
  logic [2:0] idx, idx_nxt, slot;
  logic [1:0] field;
  logic tick, blink_wrap, phase, phase_nxt;
  logic [7:0] seg_raw, seg_nxt;
  logic [NUM_DIGITS-1:0] onehot;

  time_bin2bcd_seq u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .upd    (upd),
    .hour   (hour),
    .minute (minute),
    .second (second),
    .busy   (busy),
    .done   (done),
    .digits (digits)
  );

  assign tick       = (presc == PW'(SCAN_DIV - 1));
  assign blink_wrap = (bcnt == BW'(BLINK_DIV - 1));
  assign phase_nxt  = blink_wrap ? ~phase : phase;
  assign idx_nxt    = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
  // In HHMM mode the scan skips the seconds digits, so blink_mask[0] never applies.
  assign slot       = idx_nxt + DIG_OFF;
  assign field      = slot[2:1];
  assign onehot     = NUM_DIGITS'(1) << idx_nxt;

  seg7_decoder u_dec (
    .bcd (digits[slot]),
    .seg (seg_raw)
  );

  always_comb begin
    seg_nxt = seg_raw;
`ifdef DISPLAY_COLON_BLINK_EN
    if (!phase_nxt && (slot == 3'd4 || (NUM_DIGITS == 6 && slot == 3'd2))) seg_nxt[7] = 1'b1;
`endif
    if (phase_nxt && blink_mask[field]) seg_nxt = SEG_BLANK;
  end

  // Select and segments load together on the scan tick so no mixed digit is ever driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      idx     <= '0;
      bcnt    <= '0;
      phase   <= 1'b0;
      dig_sel <= NUM_DIGITS'(1) ^ SEL_POL;
      seg_out <= SEG_DIGIT[0] ^ SEG_POL;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        idx     <= idx_nxt;
        bcnt    <= blink_wrap ? '0 : bcnt + BW'(1);
        phase   <= phase_nxt;
        dig_sel <= onehot ^ SEL_POL;
        seg_out <= seg_nxt ^ SEG_POL;
      end
    end
  end

endmodule
